mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one unified memory bus between the instruction-fetch requester and the data load/store requester of the RV32I core. It serialises both requesters onto a single outstanding bus transaction and registers all bus-side outputs. It also returns read data and a one-cycle acknowledge to the winning requester. Ties are resolved by alternation so that neither fetch nor data can starve.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
TIMEOUT_CYCLES, 255, cycles to wait for m_ack before abort (used only with the optional feature)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
i_req  in  1  fetch request; held high with i_addr stable until i_ack
i_addr  in  ADDR_W  fetch address
i_rdata  out  DATA_W  fetched word; valid while i_ack=1
i_ack  out  1  one-cycle fetch completion pulse
d_req  in  1  data request; held high with d_* inputs stable until d_ack
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_wstrb  in  DATA_W/8  byte enables for stores
d_rdata  out  DATA_W  load data; valid while d_ack=1
d_ack  out  1  one-cycle data completion pulse
m_req  out  1  bus request, registered
m_we  out  1  bus write enable, registered
m_addr  out  ADDR_W  bus address, registered
m_wdata  out  DATA_W  bus write data, registered
m_wstrb  out  DATA_W/8  bus byte enables, registered
m_rdata  in  DATA_W  bus read data; valid while m_ack=1
m_ack  in  1  bus completion pulse
err_out  out  1  abort flag; valid with i_ack/d_ack
busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, BUS_I, BUS_D, RESP. A 1-bit register last_grant holds the last winner (I or D).
- Reset: state=IDLE, last_grant=I.
- Reset: all outputs 0, including m_req, m_we, m_addr, m_wdata, m_wstrb, i_ack, d_ack, i_rdata, d_rdata, err_out and busy.
- IDLE, only i_req=1: go to BUS_I. At that edge load m_addr=i_addr, m_we=0, m_wstrb=0, m_req=1.
- IDLE, only d_req=1: go to BUS_D. At that edge load m_addr=d_addr, m_we=d_we, m_wdata=d_wdata, m_wstrb=d_wstrb (0 when d_we=0), m_req=1.
- IDLE, both requests high: grant the requester that is not last_grant. After reset, data wins the first tie. last_grant is updated on every grant.
- BUS_x: m_req and all m_* outputs hold stable until m_ack=1 is sampled.
- BUS_x, m_ack=1 sampled: m_req goes to 0, m_rdata is captured into the matching x_rdata, state goes to RESP.
- RESP: the matching x_ack is high for exactly one cycle; the other ack stays 0. Next state is IDLE.
- Latency: request sampled in IDLE at edge N → m_req=1 from N+1. m_ack sampled at edge K → x_ack=1 during cycle K+1.
- Minimum latency: 3 cycles from request to ack when m_ack=1 in the first m_req cycle.
- Requester protocol: must drop x_req, or present a new request, in the cycle after x_ack. IDLE samples again one cycle after RESP.
- A request that drops before it is granted is not an error; it is simply not served.
- m_ack while state is IDLE or RESP is ignored.
- x_rdata holds its value after the ack. For stores, d_rdata receives m_rdata unchanged (content unspecified).
- Reset mid-transaction (rst=1 in BUS_x or RESP): next edge forces IDLE with all outputs 0. No ack is issued. A late m_ack after reset is ignored.
- busy=1 in BUS_I, BUS_D and RESP; busy=0 in IDLE.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: an 8-bit-or-wider counter clears on entry to BUS_x and increments each BUS_x cycle without m_ack.
- Defined: when the counter reaches TIMEOUT_CYCLES with m_ack=0, m_req drops and state goes to RESP. The requester gets x_ack=1 with x_rdata=0 and err_out=1 for that cycle.
- Defined: m_ack in the same cycle the counter reaches the limit wins; it is treated as a normal completion with err_out=0.
- Undefined: no counter, BUS_x waits indefinitely, err_out is tied to 0.

Test Plan:
- Fetch only: i_req=1, i_addr=0x100; memory acks in first m_req cycle with 0x00500093 → m_req high 1 cycle, m_addr=0x100, m_we=0; i_ack pulses at cycle 3 with i_rdata=0x00500093; d_ack=0.
- Store: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xCAFEBABE, d_wstrb=0xF; memory waits 4 cycles → m_* stable for 5 cycles; d_ack=1 exactly once; err_out=0.
- Tie after reset: i_req and d_req both held high → order of grants is D, I, D, I; each ack matches its own address/data; no ack is duplicated.
- Reset mid-transaction: assert rst while in BUS_D, then m_ack 1 cycle later → no d_ack; m_req=0 and busy=0 after the reset edge; next i_req is served normally.
- Stray m_ack in IDLE with no requests → no ack and no state change; busy stays 0.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: i_req with m_ack never asserted → m_req drops after 8 cycles; i_ack=1 with i_rdata=0 and err_out=1; without the macro, busy stays 1 indefinitely.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundled requester and memory-bus signals of the fetch/data port arbiter.
// The arbiter takes the master view; requesters and memory take the slave view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic [DATA_W-1:0]     i_rdata;
  logic                  i_ack;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_wstrb;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_ack;
  logic                  m_req;
  logic                  m_we;
  logic [ADDR_W-1:0]     m_addr;
  logic [DATA_W-1:0]     m_wdata;
  logic [DATA_W/8-1:0]   m_wstrb;
  logic [DATA_W-1:0]     m_rdata;
  logic                  m_ack;
  logic                  err_out;
  logic                  busy;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_rdata, m_ack,
    output i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, m_wstrb,
           err_out, busy
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_rdata, m_ack,
    input  i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, m_wstrb,
           err_out, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data requests onto one registered memory bus with alternating tie-break.
// Optional bus timeout abort is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.master bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, RESP} state_t;

  state_t              r_state,      w_state_nxt;
  logic                r_last_grant, w_last_grant_nxt;
  logic                r_m_req,      w_m_req_nxt;
  logic                r_m_we,       w_m_we_nxt;
  logic [ADDR_W-1:0]   r_m_addr,     w_m_addr_nxt;
  logic [DATA_W-1:0]   r_m_wdata,    w_m_wdata_nxt;
  logic [STRB_W-1:0]   r_m_wstrb,    w_m_wstrb_nxt;
  logic [DATA_W-1:0]   r_i_rdata,    w_i_rdata_nxt;
  logic [DATA_W-1:0]   r_d_rdata,    w_d_rdata_nxt;
  logic                r_i_ack,      w_i_ack_nxt;
  logic                r_d_ack,      w_d_ack_nxt;
  logic                r_err,        w_err_nxt;
  logic                w_tmo;
  logic                w_in_bus;
  logic                w_grant_d;

  assign w_in_bus  = (r_state == BUS_I) || (r_state == BUS_D);
  // Data wins when alone, or on a tie when fetch had the previous grant.
  assign w_grant_d = bus.d_req && (!bus.i_req || (r_last_grant == GRANT_I));

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] r_tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst)                      r_tmo_cnt <= '0;
    else if (!w_in_bus)           r_tmo_cnt <= '0;
    else if (!bus.m_ack)          r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  assign w_tmo = w_in_bus && !bus.m_ack && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_m_req_nxt      = r_m_req;
    w_m_we_nxt       = r_m_we;
    w_m_addr_nxt     = r_m_addr;
    w_m_wdata_nxt    = r_m_wdata;
    w_m_wstrb_nxt    = r_m_wstrb;
    w_i_rdata_nxt    = r_i_rdata;
    w_d_rdata_nxt    = r_d_rdata;
    w_i_ack_nxt      = 1'b0;
    w_d_ack_nxt      = 1'b0;
    w_err_nxt        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_state_nxt      = BUS_D;
          w_last_grant_nxt = GRANT_D;
          w_m_req_nxt      = 1'b1;
          w_m_we_nxt       = bus.d_we;
          w_m_addr_nxt     = bus.d_addr;
          w_m_wdata_nxt    = bus.d_wdata;
          w_m_wstrb_nxt    = bus.d_we ? bus.d_wstrb : '0;
        end else if (bus.i_req) begin
          w_state_nxt      = BUS_I;
          w_last_grant_nxt = GRANT_I;
          w_m_req_nxt      = 1'b1;
          w_m_we_nxt       = 1'b0;
          w_m_addr_nxt     = bus.i_addr;
          w_m_wstrb_nxt    = '0;
        end
      end
      BUS_I, BUS_D: begin
        // A completion in the same cycle as the limit takes priority over the abort.
        if (bus.m_ack || w_tmo) begin
          w_state_nxt = RESP;
          w_m_req_nxt = 1'b0;
          w_err_nxt   = !bus.m_ack;
          if (r_state == BUS_I) begin
            w_i_ack_nxt   = 1'b1;
            w_i_rdata_nxt = bus.m_ack ? bus.m_rdata : '0;
          end else begin
            w_d_ack_nxt   = 1'b1;
            w_d_rdata_nxt = bus.m_ack ? bus.m_rdata : '0;
          end
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_I;
      r_m_req      <= 1'b0;
      r_m_we       <= 1'b0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
      r_m_wstrb    <= '0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
      r_i_ack      <= 1'b0;
      r_d_ack      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_m_req      <= w_m_req_nxt;
      r_m_we       <= w_m_we_nxt;
      r_m_addr     <= w_m_addr_nxt;
      r_m_wdata    <= w_m_wdata_nxt;
      r_m_wstrb    <= w_m_wstrb_nxt;
      r_i_rdata    <= w_i_rdata_nxt;
      r_d_rdata    <= w_d_rdata_nxt;
      r_i_ack      <= w_i_ack_nxt;
      r_d_ack      <= w_d_ack_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign bus.m_req   = r_m_req;
  assign bus.m_we    = r_m_we;
  assign bus.m_addr  = r_m_addr;
  assign bus.m_wdata = r_m_wdata;
  assign bus.m_wstrb = r_m_wstrb;
  assign bus.i_rdata = r_i_rdata;
  assign bus.d_rdata = r_d_rdata;
  assign bus.i_ack   = r_i_ack;
  assign bus.d_ack   = r_d_ack;
  assign bus.err_out = r_err;
  assign bus.busy    = (r_state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table plus an ack scoreboard and a few multi-cycle sequences.
module tb_mem_port_arbiter;
  localparam logic [31:0] HKEY = 32'hA5A5_0000;

  logic clk, rst;
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          delay;
    logic [31:0] mem_rdata;
    logic        exp_we;
    logic [3:0]  exp_wstrb;
    int          exp_lat;
    int          exp_mreq;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   ack_seen = 0;

  int          mem_delay = 0;
  int          mem_wait  = 0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_hash  = 1'b0;
  logic        mem_mute  = 1'b0;
  logic        mem_force = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input string what);
    n_chk++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Memory model: drives m_ack a little after the falling edge so control changes are seen.
  initial begin
    bus.m_ack   = 1'b0;
    bus.m_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      if (mem_force) begin
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'hBAD0_BAD0;
      end else if (bus.m_req && !mem_mute) begin
        if (mem_wait >= mem_delay) begin
          bus.m_ack   = 1'b1;
          bus.m_rdata = mem_hash ? (bus.m_addr ^ HKEY) : mem_rdata;
          mem_wait    = 0;
        end else begin
          bus.m_ack = 1'b0;
          mem_wait++;
        end
      end else begin
        bus.m_ack = 1'b0;
        mem_wait  = 0;
      end
    end
  end

  // Scoreboard: every ack must match the oldest expected completion.
  always @(negedge clk) begin
    if (bus.i_ack || bus.d_ack) begin
      exp_t e;
      ack_seen++;
      chk("ack_both_high", {31'd0, bus.i_ack & bus.d_ack}, 32'd0);
      if (sb_q.size() == 0) begin
        fail_now("unexpected_ack", $sformatf("got i_ack=%0b d_ack=%0b, expected no ack", bus.i_ack, bus.d_ack));
      end else begin
        e = sb_q.pop_front();
        chk("ack_port_is_d", {31'd0, bus.d_ack}, {31'd0, e.is_d});
        chk("ack_rdata", e.is_d ? bus.d_rdata : bus.i_rdata, e.rdata);
        chk("ack_err_out", {31'd0, bus.err_out}, {31'd0, e.err});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int   cyc;
    int   mreq;
    logic bad;
    logic got;
    mem_delay = v.delay;
    mem_rdata = v.mem_rdata;
    mem_hash  = 1'b0;
    sb_q.push_back('{v.is_d, v.mem_rdata, 1'b0});
    if (v.is_d) begin
      bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr;
      bus.d_wdata = v.wdata; bus.d_wstrb = v.wstrb;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = v.addr;
    end
    cyc = 0; mreq = 0; bad = 1'b0; got = 1'b0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.i_ack || bus.d_ack) begin
        got = 1'b1;
        break;
      end
      if (bus.m_req) begin
        mreq++;
        if (bus.m_addr !== v.addr || bus.m_we !== v.exp_we || bus.m_wstrb !== v.exp_wstrb ||
            (v.we && bus.m_wdata !== v.wdata)) bad = 1'b1;
      end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    if (!got) fail_now("vec_ack_wait", "no ack within 100 cycles, expected one");
    chk("vec_latency", cyc, v.exp_lat);
    chk("vec_mreq_cycles", mreq, v.exp_mreq);
    chk("vec_m_bus_stable", {31'd0, bad}, 32'd0);
    @(negedge clk);
    chk("vec_busy_after", {31'd0, bus.busy}, 32'd0);
    chk("vec_rdata_hold", v.is_d ? bus.d_rdata : bus.i_rdata, v.mem_rdata);
  endtask

  vec_t vt[5];

  initial begin
    int a0;
    int n;
    int cyc;
    int mreq;

    //        is_d we addr          wdata         strb dly mem_rdata     e_we e_strb lat mreq
    vt[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,        4'h0, 0, 32'h0050_0093, 1'b0, 4'h0, 2, 1};
    vt[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'hCAFE_BABE, 4'hF, 4, 32'h1111_2222, 1'b1, 4'hF, 6, 5};
    vt[2] = '{1'b1, 1'b0, 32'h0000_3004, 32'h0,        4'hF, 1, 32'hDEAD_BEEF, 1'b0, 4'h0, 3, 2};
    vt[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,        4'h0, 2, 32'h1234_5678, 1'b0, 4'h0, 4, 3};
    vt[4] = '{1'b1, 1'b1, 32'h0000_0040, 32'h0000_A5A5, 4'h3, 0, 32'hFFFF_0000, 1'b1, 4'h3, 2, 1};

    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
    repeat (3) @(negedge clk);
    chk("rst_m_req",   {31'd0, bus.m_req},   32'd0);
    chk("rst_m_we",    {31'd0, bus.m_we},    32'd0);
    chk("rst_m_addr",  bus.m_addr,           32'd0);
    chk("rst_m_wdata", bus.m_wdata,          32'd0);
    chk("rst_m_wstrb", {28'd0, bus.m_wstrb}, 32'd0);
    chk("rst_acks",    {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
    chk("rst_i_rdata", bus.i_rdata,          32'd0);
    chk("rst_d_rdata", bus.d_rdata,          32'd0);
    chk("rst_err_out", {31'd0, bus.err_out}, 32'd0);
    chk("rst_busy",    {31'd0, bus.busy},    32'd0);
    rst = 1'b0;

    for (int k = 0; k < 5; k++) run_vec(vt[k]);

    // Stray m_ack while idle must be ignored.
    a0 = ack_seen;
    mem_force = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_busy", {31'd0, bus.busy}, 32'd0);
    end
    mem_force = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_no_ack", ack_seen, a0);
    chk("stray_m_req", {31'd0, bus.m_req}, 32'd0);

    // Tie after reset: grants alternate D, I, D, I.
    do_reset();
    mem_delay = 0;
    mem_hash  = 1'b1;
    sb_q.push_back('{1'b1, 32'h0000_0600 ^ HKEY, 1'b0});
    sb_q.push_back('{1'b0, 32'h0000_0500 ^ HKEY, 1'b0});
    sb_q.push_back('{1'b1, 32'h0000_0600 ^ HKEY, 1'b0});
    sb_q.push_back('{1'b0, 32'h0000_0500 ^ HKEY, 1'b0});
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0500;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0600; bus.d_wstrb = 4'h0;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.i_ack || bus.d_ack) n++;
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    chk("tie_ack_count", n, 4);
    repeat (4) @(negedge clk);
    chk("tie_queue_empty", sb_q.size(), 0);
    chk("tie_busy_end", {31'd0, bus.busy}, 32'd0);
    mem_hash = 1'b0;

    // Reset during BUS_D, then a late m_ack.
    mem_mute = 1'b1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_0700;
    bus.d_wdata = 32'h55AA_55AA; bus.d_wstrb = 4'hF;
    repeat (2) @(negedge clk);
    chk("rstmid_busy_pre",  {31'd0, bus.busy},  32'd1);
    chk("rstmid_m_req_pre", {31'd0, bus.m_req}, 32'd1);
    a0 = ack_seen;
    rst = 1'b1;
    bus.d_req = 1'b0;
    @(negedge clk);
    chk("rstmid_m_req",  {31'd0, bus.m_req}, 32'd0);
    chk("rstmid_busy",   {31'd0, bus.busy},  32'd0);
    chk("rstmid_m_addr", bus.m_addr,         32'd0);
    rst = 1'b0;
    mem_mute = 1'b0;
    mem_force = 1'b1;
    @(negedge clk);
    mem_force = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_no_ack", ack_seen, a0);
    chk("rstmid_busy_post", {31'd0, bus.busy}, 32'd0);
    run_vec(vt[3]);

`ifdef ARB_TIMEOUT_EN
    mem_mute = 1'b1;
    sb_q.push_back('{1'b0, 32'h0, 1'b1});
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0900;
    cyc = 0; mreq = 0; n = 0;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (bus.i_ack) begin
        n = 1;
        break;
      end
      if (bus.m_req) mreq++;
    end
    bus.i_req = 1'b0;
    mem_mute = 1'b0;
    chk("tmo_acked", n, 1);
    chk("tmo_mreq_cycles", mreq, 8);
    chk("tmo_latency", cyc, 9);
    @(negedge clk);
    chk("tmo_busy_after", {31'd0, bus.busy}, 32'd0);
`else
    mem_mute = 1'b1;
    a0 = ack_seen;
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0900;
    repeat (20) @(negedge clk);
    chk("notmo_busy",  {31'd0, bus.busy},  32'd1);
    chk("notmo_m_req", {31'd0, bus.m_req}, 32'd1);
    chk("notmo_no_ack", ack_seen, a0);
    chk("notmo_err_out", {31'd0, bus.err_out}, 32'd0);
    do_reset();
    mem_mute = 1'b0;
    chk("notmo_busy_rst", {31'd0, bus.busy}, 32'd0);
`endif

    repeat (2) @(negedge clk);
    chk("final_queue_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
